// File: rtl/bcd_display_driver.sv
// Time-multiplexed 7-segment driver for a packed BCD value, with frame-aligned updates.
// Optional leading-zero blanking is enabled by defining BCD_DISP_LZB_EN.
module bcd_display_driver #(
    parameter int DIGITS = 2,
    parameter int DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

    logic [4*DIGITS-1:0] disp;
    logic [4*DIGITS-1:0] pend;
    logic                pend_full;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;
    logic                transfer;
    logic [3:0]          cur_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1111001;  // non-BCD digit shows "E"
        endcase
    endfunction

    assign frame_done = (idx == IDX_LAST) && (cnt == CNT_LAST);
    // A full pending slot frees up on the frame boundary, so accept again then.
    assign in_ready   = !pend_full || frame_done;
    assign transfer   = in_valid && in_ready;
    assign an         = AN_ONE << idx;
    assign cur_digit  = disp[4*int'(idx) +: 4];

`ifdef BCD_DISP_LZB_EN
    logic [DIGITS-1:0] blank;

    always_comb begin
        logic zero_above;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        blank      = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above && (disp[4*k +: 4] == 4'd0);
            blank[k]   = zero_above;
        end
    end

    assign seg = blank[idx] ? 7'b0000000 : decode(cur_digit);
`else
    assign seg = decode(cur_digit);
`endif

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (frame_done && pend_full)
                disp <= pend;

            if (transfer) begin
                pend      <= in_bcd;
                pend_full <= 1'b1;
            end else if (frame_done) begin
                pend_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver (DIGITS=2, DIV=4): decode table,
// directed frame/handshake sequences and randomized traffic against a cycle model.
module tb_bcd_display_driver;

    localparam int DIGITS = 2;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_bcd;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_done;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: position in frame from a cycle count, plus shown/pending values.
    int         t;
    logic [7:0] m_disp;
    logic [7:0] m_pend;
    bit         m_full;
    bit         m_xfer;

    always #5 clk = ~clk;

    bcd_display_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bcd     (in_bcd),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b1111001;
        endcase
    endfunction

    function automatic logic [6:0] model_seg();
        int k;
        int upper;
        k     = (t % FRAME) / DIV;
        upper = int'(m_disp) >> (4 * k);
`ifdef BCD_DISP_LZB_EN
        if (k > 0 && upper == 0) return 7'b0000000;
`endif
        return glyph(upper % 16);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, t, act, exp);
        end
    endtask

    task automatic check_model();
        int  k;
        bit  fd;
        k  = (t % FRAME) / DIV;
        fd = (t % FRAME) == FRAME - 1;
        check("model_seg", 8'(seg), 8'(model_seg()));
        check("model_an", 8'(an), 8'(1 << k));
        check("model_frame_done", 8'(frame_done), 8'(fd));
        check("model_in_ready", 8'(in_ready), 8'(!m_full || fd));
    endtask

    task automatic model_edge();
        bit fd;
        if (rst) begin
            t      = 0;
            m_disp = '0;
            m_pend = '0;
            m_full = 1'b0;
            m_xfer = 1'b0;
        end else begin
            fd     = (t % FRAME) == FRAME - 1;
            m_xfer = in_valid && (!m_full || fd);
            if (fd && m_full) m_disp = m_pend;
            if (m_xfer) begin
                m_pend = in_bcd;
                m_full = 1'b1;
            end else if (fd) begin
                m_full = 1'b0;
            end
            t++;
        end
    endtask

    task automatic step();
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        in_valid = v;
        in_bcd   = b;
        step();
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bcd   = '0;
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] d0;
        logic [6:0] d1;
    } vec_t;

    vec_t tbl [7];

    initial begin
`ifdef BCD_DISP_LZB_EN
        localparam logic [6:0] LEAD_ZERO = 7'b0000000;
`else
        localparam logic [6:0] LEAD_ZERO = 7'b0111111;
`endif
        tbl[0] = '{8'h42, 7'b1011011, 7'b1100110};
        tbl[1] = '{8'hA5, 7'b1101101, 7'b1111001};
        tbl[2] = '{8'h07, 7'b0000111, LEAD_ZERO};
        tbl[3] = '{8'h00, 7'b0111111, LEAD_ZERO};
        tbl[4] = '{8'h98, 7'b1111111, 7'b1101111};
        tbl[5] = '{8'h6F, 7'b1111001, 7'b1111101};
        tbl[6] = '{8'h31, 7'b0000110, 7'b1001111};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_bcd   = '0;
        t        = 0;
        m_disp   = '0;
        m_pend   = '0;
        m_full   = 1'b0;
        m_xfer   = 1'b0;

        // Reset state and frame_done placement.
        reset_dut();
        check("rst_an", 8'(an), 8'h01);
        check("rst_seg", 8'(seg), 8'(7'b0111111));
        check("rst_ready", 8'(in_ready), 8'h01);
        for (int c = 0; c < 24; c++) begin
            check("rst_frame_done", 8'(frame_done), 8'(c % 8 == 7));
            drive(1'b0, 8'h00);
        end

        // Decode table: value accepted at cycle 0 is shown in the frame starting at cycle 8.
        for (int i = 0; i < 7; i++) begin
            reset_dut();
            drive(1'b1, tbl[i].bcd);
            for (int c = 1; c < 8; c++) drive(1'b0, 8'h00);
            check("tbl_d0_seg", 8'(seg), 8'(tbl[i].d0));
            check("tbl_d0_an", 8'(an), 8'h01);
            repeat (4) drive(1'b0, 8'h00);
            check("tbl_d1_seg", 8'(seg), 8'(tbl[i].d1));
            check("tbl_d1_an", 8'(an), 8'h02);
        end

        // Basic latency: 0x42 at cycle 2.
        reset_dut();
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        drive(1'b1, 8'h42);
        for (int c = 3; c < 8; c++) drive(1'b0, 8'h00);
        for (int c = 8; c < 16; c++) begin
            check("basic_seg", 8'(seg), 8'(c < 12 ? 7'b1011011 : 7'b1100110));
            drive(1'b0, 8'h00);
        end

        // Back-pressure: 0x11 at cycle 1, 0x99 offered from cycle 3.
        reset_dut();
        drive(1'b0, 8'h00);
        drive(1'b1, 8'h11);
        for (int c = 2; c < 8; c++) begin
            in_valid = (c >= 3);
            in_bcd   = (c >= 3) ? 8'h99 : 8'h00;
            check("bp_ready", 8'(in_ready), 8'(c == 7));
            step();
        end
        in_valid = 1'b0;
        in_bcd   = 8'h00;
        check("bp_first_seg", 8'(seg), 8'(7'b0000110));
        repeat (8) step();
        check("bp_second_seg", 8'(seg), 8'(7'b1101111));

        // Simultaneous frame boundary and transfer: 0x61 pending, 0x37 at cycle 15.
        reset_dut();
        drive(1'b1, 8'h55);
        for (int c = 1; c < 9; c++) drive(1'b0, 8'h00);
        check("sim_ready_free", 8'(in_ready), 8'h01);
        drive(1'b1, 8'h61);
        for (int c = 10; c < 15; c++) begin
            check("sim_ready_busy", 8'(in_ready), 8'h00);
            drive(1'b0, 8'h00);
        end
        in_valid = 1'b1;
        in_bcd   = 8'h37;
        check("sim_ready_fd", 8'(in_ready), 8'h01);
        step();
        in_valid = 1'b0;
        in_bcd   = 8'h00;
        check("sim_old_pend", 8'(seg), 8'(7'b0000110));
        repeat (8) step();
        check("sim_new_d0", 8'(seg), 8'(7'b0000111));
        repeat (4) step();
        check("sim_new_d1", 8'(seg), 8'(7'b1001111));

        // Reset held mid-frame discards the pending value and restarts the scan.
        reset_dut();
        drive(1'b1, 8'h88);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        check("rh_an", 8'(an), 8'h01);
        check("rh_ready", 8'(in_ready), 8'h01);
        for (int c = 0; c < 8; c++) begin
            check("rh_frame_done", 8'(frame_done), 8'(c == 7));
            step();
        end
        check("rh_discarded", 8'(seg), 8'(7'b0111111));

        // Randomized traffic honouring the hold-while-stalled rule, with rare resets.
        reset_dut();
        in_valid = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!(in_valid && !m_xfer && !rst)) begin
                in_valid = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 1) == 0)
                    in_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                else
                    in_bcd = 8'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
